// File: rtl/lcd_frame_driver_pkg.sv
// Shared definitions for the character LCD frame driver: HD44780 command
// codes, the blank character, and the state encodings of both FSMs.
`timescale 1ns/1ps
package lcd_frame_driver_pkg;

   localparam logic [7:0] CMD_FUNC_SET = 8'h28;  // 4-bit bus, 2 lines, 5x8 font
   localparam logic [7:0] CMD_ENTRY    = 8'h06;  // increment, no shift
   localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
   localparam logic [7:0] CMD_CLEAR    = 8'h01;
   localparam logic [7:0] CMD_DDRAM_L1 = 8'h80;
   localparam logic [7:0] CMD_DDRAM_L2 = 8'hC0;
   localparam logic [7:0] CHAR_SPACE   = 8'h20;

   typedef enum logic [2:0] {
      PWR_WAIT, INIT_NIB, INIT_CMD, IDLE, SET_L1, WR_L1, SET_L2, WR_L2
   } state_t;

   typedef enum logic [2:0] {
      TX_IDLE, TX_SETUP, TX_HIGH, TX_HOLD, TX_GAP, TX_POST
   } tx_state_t;

   // Full-byte part of the init sequence, in order.
   function automatic logic [7:0] init_cmd(input logic [1:0] i);
      case (i)
         2'd0:    return CMD_FUNC_SET;
         2'd1:    return CMD_ENTRY;
         2'd2:    return CMD_DISP_ON;
         default: return CMD_CLEAR;
      endcase
   endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// Sends one byte (or a single high nibble) to the LCD in 4-bit mode and then
// waits a caller-chosen delay. Owns the one shared 20-bit down-counter, so
// plain waits (delay_only) are also run through here.
`timescale 1ns/1ps
module lcd_byte_tx
   import lcd_frame_driver_pkg::*;
#(
   parameter int T_E_HIGH  = 12,
   parameter int T_SETUP   = 2,
   parameter int T_NIB_GAP = 50
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        rs,
   input  logic [7:0]  data,
   input  logic        nibble_only,
   input  logic        delay_only,
   input  logic [19:0] post_delay,
   output logic        done,
   output logic [3:0]  SF_D,
   output logic        LCD_E,
   output logic        LCD_RS
);

   localparam logic [19:0] SETUP_LD = 20'(T_SETUP - 1);
   localparam logic [19:0] EHIGH_LD = 20'(T_E_HIGH - 1);
   localparam logic [19:0] GAP_LD   = 20'(T_NIB_GAP - 1);

   tx_state_t   state, state_next;
   logic [19:0] cnt, cnt_next, post, post_next;
   logic [7:0]  data_q, data_q_next;
   logic        only, only_next, low, low_next, done_next;
   logic [3:0]  sf_d_next;
   logic        e_next, rs_next;

   // State, counter and pin registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= TX_IDLE;
         cnt    <= '0;
         post   <= '0;
         data_q <= '0;
         only   <= 1'b0;
         low    <= 1'b0;
         done   <= 1'b0;
         SF_D   <= '0;
         LCD_E  <= 1'b0;
         LCD_RS <= 1'b0;
      end else begin
         state  <= state_next;
         cnt    <= cnt_next;
         post   <= post_next;
         data_q <= data_q_next;
         only   <= only_next;
         low    <= low_next;
         done   <= done_next;
         SF_D   <= sf_d_next;
         LCD_E  <= e_next;
         LCD_RS <= rs_next;
      end
   end

   // Strobe sequencing: setup, E high, hold, optional gap + low nibble, post delay.
   always_comb begin
      state_next  = state;
      cnt_next    = cnt - 20'd1;
      post_next   = post;
      data_q_next = data_q;
      only_next   = only;
      low_next    = low;
      done_next   = 1'b0;
      sf_d_next   = SF_D;
      e_next      = LCD_E;
      rs_next     = LCD_RS;
      case (state)
         TX_IDLE: begin
            cnt_next = cnt;
            if (start) begin
               data_q_next = data;
               only_next   = nibble_only;
               post_next   = post_delay;
               low_next    = 1'b0;
               if (delay_only) begin
                  cnt_next   = post_delay - 20'd1;
                  state_next = TX_POST;
               end else begin
                  sf_d_next  = data[7:4];
                  rs_next    = rs;
                  cnt_next   = SETUP_LD;
                  state_next = TX_SETUP;
               end
            end
         end
         TX_SETUP: if (cnt == '0) begin
            e_next     = 1'b1;
            cnt_next   = EHIGH_LD;
            state_next = TX_HIGH;
         end
         TX_HIGH: if (cnt == '0) begin
            e_next     = 1'b0;
            cnt_next   = SETUP_LD;
            state_next = TX_HOLD;
         end
         TX_HOLD: if (cnt == '0) begin
            if (!low && !only) begin
               cnt_next   = GAP_LD;
               state_next = TX_GAP;
            end else begin
               cnt_next   = post - 20'd1;
               state_next = TX_POST;
            end
         end
         TX_GAP: if (cnt == '0) begin
            sf_d_next  = data_q[3:0];
            low_next   = 1'b1;
            cnt_next   = SETUP_LD;
            state_next = TX_SETUP;
         end
         TX_POST: if (cnt == '0) begin
            done_next  = 1'b1;
            cnt_next   = cnt;
            state_next = TX_IDLE;
         end
         default: state_next = TX_IDLE;
      endcase
   end

endmodule

// File: rtl/lcd_frame_driver.sv
// 2x16 character frame buffer plus the init/repaint sequencer for an
// HD44780-style LCD. Optional build macro LCD_SHADOW_EN snapshots the buffer
// at the start of each repaint so mid-repaint writes cannot tear the frame.
`timescale 1ns/1ps
module lcd_frame_driver
   import lcd_frame_driver_pkg::*;
#(
   parameter int T_PWRUP     = 750000,
   parameter int T_INIT_LONG = 205000,
   parameter int T_INIT_MID  = 5000,
   parameter int T_E_HIGH    = 12,
   parameter int T_SETUP     = 2,
   parameter int T_NIB_GAP   = 50,
   parameter int T_CMD       = 2000,
   parameter int T_CLEAR     = 82000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] dat,
   input  logic [4:0] addr,
   input  logic       we,
   input  logic       repaint,
   output logic       busy,
   output logic [3:0] SF_D,
   output logic       LCD_E,
   output logic       LCD_RS
);

   state_t           state, state_next;
   logic [3:0]       idx, idx_next;
   logic             issued, issued_next, pending, pending_next;
   logic [31:0][7:0] buffer, char_src;
   logic             start, tx_rs, nib_only, delay_only, tx_done;
   logic [7:0]       tx_data;
   logic [19:0]      post;

   // Frame buffer: writable every cycle, blank after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)     buffer       <= {32{CHAR_SPACE}};
      else if (we) buffer[addr] <= dat;
   end

`ifdef LCD_SHADOW_EN
   logic [31:0][7:0] shadow;
   // Snapshot the whole frame as a repaint begins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) shadow <= {32{CHAR_SPACE}};
      else if (state_next == SET_L1 && state != SET_L1) shadow <= buffer;
   end
   assign char_src = shadow;
`else
   assign char_src = buffer;
`endif

   assign busy = (state != IDLE);

   // Sequencer state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= PWR_WAIT;
         idx     <= '0;
         issued  <= 1'b0;
         pending <= 1'b0;
      end else begin
         state   <= state_next;
         idx     <= idx_next;
         issued  <= issued_next;
         pending <= pending_next;
      end
   end

   // Per-state transfer descriptor and next-state logic; each step launches
   // one transfer and advances when the transmitter reports done.
   always_comb begin
      state_next   = state;
      idx_next     = idx;
      issued_next  = issued;
      pending_next = pending;
      start        = 1'b0;
      tx_rs        = 1'b0;
      tx_data      = 8'h00;
      nib_only     = 1'b0;
      delay_only   = 1'b0;
      post         = 20'(T_CMD);

      if (repaint && state != IDLE) pending_next = 1'b1;

      case (state)
         PWR_WAIT: begin
            delay_only = 1'b1;
            post       = 20'(T_PWRUP);
         end
         INIT_NIB: begin
            nib_only = 1'b1;
            tx_data  = (idx == 4'd3) ? 8'h20 : 8'h30;
            if (idx == 4'd0)      post = 20'(T_INIT_LONG);
            else if (idx == 4'd1) post = 20'(T_INIT_MID);
         end
         INIT_CMD: begin
            tx_data = init_cmd(idx[1:0]);
            if (idx == 4'd3) post = 20'(T_CLEAR);
         end
         SET_L1: tx_data = CMD_DDRAM_L1;
         SET_L2: tx_data = CMD_DDRAM_L2;
         WR_L1, WR_L2: begin
            tx_rs   = 1'b1;
            tx_data = char_src[{state == WR_L2, idx}];
         end
         default: ;
      endcase

      if (state == IDLE) begin
         if (repaint) begin
            state_next  = SET_L1;
            idx_next    = '0;
            issued_next = 1'b0;
         end
      end else if (!issued) begin
         start       = 1'b1;
         issued_next = 1'b1;
      end else if (tx_done) begin
         issued_next = 1'b0;
         idx_next    = idx + 4'd1;
         case (state)
            PWR_WAIT: state_next = INIT_NIB;
            INIT_NIB: if (idx == 4'd3) state_next = INIT_CMD;
            SET_L1:   state_next = WR_L1;
            WR_L1:    if (idx == 4'd15) state_next = SET_L2;
            SET_L2:   state_next = WR_L2;
            INIT_CMD, WR_L2: begin
               if ((state == INIT_CMD && idx == 4'd3) || (state == WR_L2 && idx == 4'd15)) begin
                  // A queued request (or one arriving now) chains straight on.
                  state_next   = (pending || repaint) ? SET_L1 : IDLE;
                  pending_next = 1'b0;
               end
            end
            default: state_next = IDLE;
         endcase
         if (state_next != state) idx_next = '0;
      end
   end

   lcd_byte_tx #(
      .T_E_HIGH  (T_E_HIGH),
      .T_SETUP   (T_SETUP),
      .T_NIB_GAP (T_NIB_GAP)
   ) u_tx (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .rs          (tx_rs),
      .data        (tx_data),
      .nibble_only (nib_only),
      .delay_only  (delay_only),
      .post_delay  (post),
      .done        (tx_done),
      .SF_D        (SF_D),
      .LCD_E       (LCD_E),
      .LCD_RS      (LCD_RS)
   );

endmodule
